// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: accepts an 8-bit request vector and streams the
// 3-bit index of every set bit, one per beat, in fixed priority order.
module encoder_8to3_seq #(
    parameter int PRIORITY_MSB = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] en_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] en_out,
    output logic       out_last,
    output logic       zero_drop
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] pending_r;
    logic [7:0] pending_s;
    logic [7:0] cleared_s;
    logic       zero_s;
    logic       in_ready_s;
    logic       out_valid_s;
    logic [2:0] en_out_s;
    logic       out_last_s;

    // Index of the highest-priority set bit; the last match in scan order wins.
    function automatic logic [2:0] prio_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_MSB != 0) begin
            for (int i = 0; i < 8; i++) idx = vec[i] ? 3'(i) : idx;
        end else begin
            for (int i = 7; i >= 0; i--) idx = vec[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [7:0] vec);
        return (vec != 8'h00) && ((vec & (vec - 8'd1)) == 8'h00);
    endfunction

    // State and pending-vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pending_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
        end
    end

    // Next-state logic: accept in IDLE, retire one index per handshake in EMIT.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        zero_s    = 1'b0;
        cleared_s = pending_r & ~(8'd1 << prio_index(pending_r));
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (en_in != 8'h00) begin
                        pending_s = en_in;
                        state_s   = EMIT;
                    end else begin
                        zero_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_s = cleared_s;
                    state_s   = (cleared_s == 8'h00) ? IDLE : EMIT;
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s   = IDLE;
                pending_s = 8'h00;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered
    // without adding a cycle of latency.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        en_out_s    = 3'd0;
        out_last_s  = 1'b0;
        case (state_s)
            IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            EMIT: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
                en_out_s    = prio_index(pending_s);
                out_last_s  = is_single(pending_s);
            end
            default: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            en_out    <= 3'd0;
            out_last  <= 1'b0;
            zero_drop <= 1'b0;
        end else begin
            in_ready  <= in_ready_s;
            out_valid <= out_valid_s;
            en_out    <= en_out_s;
            out_last  <= out_last_s;
            zero_drop <= zero_s;
        end
    end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed self-checking bench for encoder_8to3_seq, covering both scan orders.
module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b1;
    logic [7:0] en_in = 8'hFF;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, zero_drop;
    logic [2:0] en_out;

    logic       in_valid_m = 1'b0;
    logic [7:0] en_in_m = 8'h00;
    logic       out_ready_m = 1'b1;
    logic       in_ready_m, out_valid_m, out_last_m, zero_drop_m;
    logic [2:0] en_out_m;

    int pass_cnt = 0;
    int total_cnt = 0;

    // {in_ready, out_valid, en_out, out_last, zero_drop}
    logic [6:0] obs, obs_m;
    assign obs   = {in_ready, out_valid, en_out, out_last, zero_drop};
    assign obs_m = {in_ready_m, out_valid_m, en_out_m, out_last_m, zero_drop_m};

    localparam logic [6:0] IDLE_OBS = 7'b1000000;

    always #5 clk = ~clk;

    encoder_8to3_seq #(.PRIORITY_MSB(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .en_in(en_in), .out_valid(out_valid), .out_ready(out_ready),
        .en_out(en_out), .out_last(out_last), .zero_drop(zero_drop)
    );

    encoder_8to3_seq #(.PRIORITY_MSB(1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .en_in(en_in_m), .out_valid(out_valid_m), .out_ready(out_ready_m),
        .en_out(en_out_m), .out_last(out_last_m), .zero_drop(zero_drop_m)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL reset_cycle1 got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL reset_cycle2 got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL reset_release got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
        total_cnt++;
        if (obs_m !== IDLE_OBS) $display("FAIL reset_msb got %b want %b", obs_m, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_onehot();
        logic [7:0] v;
        logic [6:0] exp;
        for (int i = 0; i < 8; i++) begin
            v = 8'd1 << i;
            en_in = v;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            exp = {1'b0, 1'b1, 3'(i), 1'b1, 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL onehot_beat idx=%0d got %b want %b", i, obs, exp);
            else pass_cnt++;
            step();
            total_cnt++;
            if (obs !== IDLE_OBS) $display("FAIL onehot_idle idx=%0d got %b want %b", i, obs, IDLE_OBS);
            else pass_cnt++;
        end
    endtask

    task automatic test_multi();
        logic [2:0] idx [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [6:0] exp;
        en_in = 8'b10100101;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            exp = {1'b0, 1'b1, idx[j], (j == 3), 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL multi_beat%0d got %b want %b", j, obs, exp);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL multi_return_idle got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        en_in = 8'b00011000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        en_in = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (obs !== 7'b0101100) $display("FAIL bp_hold%0d got %b want %b", c, obs, 7'b0101100);
            else pass_cnt++;
            if (c == 3) out_ready = 1'b1;
            step();
        end
        total_cnt++;
        if (obs !== 7'b0110010) $display("FAIL bp_last got %b want %b", obs, 7'b0110010);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL bp_idle got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
        en_in = 8'h00;
    endtask

    task automatic test_zero();
        en_in = 8'h00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (obs !== 7'b1000001) $display("FAIL zero_pulse got %b want %b", obs, 7'b1000001);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL zero_after got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_msb_order();
        logic [6:0] exp;
        en_in_m = 8'hFF;
        in_valid_m = 1'b1;
        step();
        in_valid_m = 1'b0;
        en_in_m = 8'h00;
        for (int j = 0; j < 8; j++) begin
            exp = {1'b0, 1'b1, 3'(7 - j), (j == 7), 1'b0};
            total_cnt++;
            if (obs_m !== exp) $display("FAIL msb_beat%0d got %b want %b", j, obs_m, exp);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (obs_m !== IDLE_OBS) $display("FAIL msb_idle got %b want %b", obs_m, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        en_in = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        total_cnt++;
        if (obs !== 7'b0101100) $display("FAIL midop_beat3 got %b want %b", obs, 7'b0101100);
        else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL midop_reset got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
        en_in = 8'h40;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (obs !== 7'b0111010) $display("FAIL midop_next got %b want %b", obs, 7'b0111010);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL midop_idle got %b want %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_multi();
        test_backpressure();
        test_zero();
        test_msb_order();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
